// File: rtl/decode_reg_stage_module.sv
// ---------------------------------------------------------------------------
// decode_reg_stage_module
//
// Decode stage of the pipeline: the receiving end of the writeback port, the
// 32-entry register file, operand read with a same-cycle writeback bypass,
// immediate extension and the ID/EX pipeline register.
//
// Ports
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   i_RegWriteW/i_RdW/i_ResultW
//                            writeback write enable, destination, data
//   i_InstrD, i_PCD, i_PCPlus4D
//                            instruction and PCs from the IF/ID register
//   i_ImmSrcD                00 I, 01 S, 10 B, 11 J immediate format
//   i_RegWriteD .. i_JumpD, i_ALUControlD
//                            decode-stage control from the control unit
//   i_FlushE                 turns the next ID/EX load into a bubble
//   o_Rs1D, o_Rs2D           source indices straight from InstrD (hazard unit)
//   o_*E                     registered ID/EX outputs to the execute stage
// ---------------------------------------------------------------------------
module decode_reg_stage_module #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_RegWriteW,
    input  logic [AW-1:0]   i_RdW,
    input  logic [XLEN-1:0] i_ResultW,
    input  logic [31:0]     i_InstrD,
    input  logic [XLEN-1:0] i_PCD,
    input  logic [XLEN-1:0] i_PCPlus4D,
    input  logic [1:0]      i_ImmSrcD,
    input  logic            i_RegWriteD,
    input  logic            i_ResultSrcD,
    input  logic            i_MemWriteD,
    input  logic            i_ALUSrcD,
    input  logic            i_BranchD,
    input  logic            i_JumpD,
    input  logic [2:0]      i_ALUControlD,
    input  logic            i_FlushE,
    output logic [AW-1:0]   o_Rs1D,
    output logic [AW-1:0]   o_Rs2D,
    output logic [XLEN-1:0] o_RD1E,
    output logic [XLEN-1:0] o_RD2E,
    output logic [XLEN-1:0] o_ImmExtE,
    output logic [AW-1:0]   o_Rs1E,
    output logic [AW-1:0]   o_Rs2E,
    output logic [AW-1:0]   o_RdE,
    output logic [XLEN-1:0] o_PCE,
    output logic [XLEN-1:0] o_PCPlus4E,
    output logic            o_RegWriteE,
    output logic            o_ResultSrcE,
    output logic            o_MemWriteE,
    output logic            o_ALUSrcE,
    output logic            o_BranchE,
    output logic            o_JumpE,
    output logic [2:0]      o_ALUControlE
);

    logic [XLEN-1:0] r_rf [NREG];

    logic [AW-1:0]   w_rs1;
    logic [AW-1:0]   w_rs2;
    logic [AW-1:0]   w_rd;
    logic [XLEN-1:0] w_rd1;
    logic [XLEN-1:0] w_rd2;
    logic [XLEN-1:0] w_immExt;
    logic            w_sign;
    logic            w_unused_opcode;

    logic [XLEN-1:0] r_rd1E, r_rd2E, r_immExtE, r_pcE, r_pcPlus4E;
    logic [AW-1:0]   r_rs1E, r_rs2E, r_rdE;
    logic            r_regWriteE, r_resultSrcE, r_memWriteE;
    logic            r_aluSrcE, r_branchE, r_jumpE;
    logic [2:0]      r_aluControlE;

    assign w_rs1  = i_InstrD[19:15];
    assign w_rs2  = i_InstrD[24:20];
    assign w_rd   = i_InstrD[11:7];
    assign w_sign = i_InstrD[31];

    // The opcode field is decoded by the control unit, not here.
    assign w_unused_opcode = ^i_InstrD[6:0];

    // x0 is never written, so its entry stays at the reset value of zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= '0;
            end
        end else if (i_RegWriteW && (i_RdW != '0)) begin
            r_rf[i_RdW] <= i_ResultW;
        end
    end

    // A register being written back this cycle is forwarded so the decode
    // read sees the new value without a half-cycle register-file write.
    always_comb begin
        w_rd1 = r_rf[w_rs1];
        w_rd2 = r_rf[w_rs2];
        if (w_rs1 == '0) begin
            w_rd1 = '0;
        end else if (i_RegWriteW && (i_RdW == w_rs1)) begin
            w_rd1 = i_ResultW;
        end
        if (w_rs2 == '0) begin
            w_rd2 = '0;
        end else if (i_RegWriteW && (i_RdW == w_rs2)) begin
            w_rd2 = i_ResultW;
        end
    end

    always_comb begin
        w_immExt = '0;
        case (i_ImmSrcD)
            2'b00: w_immExt = {{(XLEN-12){w_sign}}, i_InstrD[31:20]};
            2'b01: w_immExt = {{(XLEN-12){w_sign}}, i_InstrD[31:25], i_InstrD[11:7]};
            2'b10: w_immExt = {{(XLEN-13){w_sign}}, i_InstrD[31], i_InstrD[7],
                               i_InstrD[30:25], i_InstrD[11:8], 1'b0};
            default: w_immExt = {{(XLEN-21){w_sign}}, i_InstrD[31], i_InstrD[19:12],
                                 i_InstrD[20], i_InstrD[30:21], 1'b0};
        endcase
    end

    // A flush loads an all-zero bubble, which is a NOP in the execute stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || i_FlushE) begin
            r_rd1E        <= '0;
            r_rd2E        <= '0;
            r_immExtE     <= '0;
            r_rs1E        <= '0;
            r_rs2E        <= '0;
            r_rdE         <= '0;
            r_pcE         <= '0;
            r_pcPlus4E    <= '0;
            r_regWriteE   <= 1'b0;
            r_resultSrcE  <= 1'b0;
            r_memWriteE   <= 1'b0;
            r_aluSrcE     <= 1'b0;
            r_branchE     <= 1'b0;
            r_jumpE       <= 1'b0;
            r_aluControlE <= '0;
        end else begin
            r_rd1E        <= w_rd1;
            r_rd2E        <= w_rd2;
            r_immExtE     <= w_immExt;
            r_rs1E        <= w_rs1;
            r_rs2E        <= w_rs2;
            r_rdE         <= w_rd;
            r_pcE         <= i_PCD;
            r_pcPlus4E    <= i_PCPlus4D;
            r_regWriteE   <= i_RegWriteD;
            r_resultSrcE  <= i_ResultSrcD;
            r_memWriteE   <= i_MemWriteD;
            r_aluSrcE     <= i_ALUSrcD;
            r_branchE     <= i_BranchD;
            r_jumpE       <= i_JumpD;
            r_aluControlE <= i_ALUControlD;
        end
    end

    assign o_Rs1D        = w_rs1;
    assign o_Rs2D        = w_rs2;
    assign o_RD1E        = r_rd1E;
    assign o_RD2E        = r_rd2E;
    assign o_ImmExtE     = r_immExtE;
    assign o_Rs1E        = r_rs1E;
    assign o_Rs2E        = r_rs2E;
    assign o_RdE         = r_rdE;
    assign o_PCE         = r_pcE;
    assign o_PCPlus4E    = r_pcPlus4E;
    assign o_RegWriteE   = r_regWriteE;
    assign o_ResultSrcE  = r_resultSrcE;
    assign o_MemWriteE   = r_memWriteE;
    assign o_ALUSrcE     = r_aluSrcE;
    assign o_BranchE     = r_branchE;
    assign o_JumpE       = r_jumpE;
    assign o_ALUControlE = r_aluControlE;

endmodule

// File: tb/tb_decode_reg_stage_module.sv
// ---------------------------------------------------------------------------
// tb_decode_reg_stage_module
//
// Bench for the decode stage: directed scenarios plus a randomized run, all
// checked against a register-file model and an immediate model kept here.
// ---------------------------------------------------------------------------
module tb_decode_reg_stage_module;

    typedef struct packed {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] pcp4;
        logic [8:0]  ctrl;
    } eStage_t;

    logic        clk;
    logic        rst;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic [1:0]  ImmSrcD;
    logic [8:0]  ctrlD;
    logic        FlushE;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic        RegWriteE, ResultSrcE, MemWriteE, ALUSrcE, BranchE, JumpE;
    logic [2:0]  ALUControlE;

    logic [31:0] modelRf [32];
    eStage_t     expE;
    logic        checkEn;
    int          testsRun;
    int          failures;

    decode_reg_stage_module dut (
        .clk           (clk),
        .rst           (rst),
        .i_RegWriteW   (RegWriteW),
        .i_RdW         (RdW),
        .i_ResultW     (ResultW),
        .i_InstrD      (InstrD),
        .i_PCD         (PCD),
        .i_PCPlus4D    (PCPlus4D),
        .i_ImmSrcD     (ImmSrcD),
        .i_RegWriteD   (ctrlD[8]),
        .i_ResultSrcD  (ctrlD[7]),
        .i_MemWriteD   (ctrlD[6]),
        .i_ALUSrcD     (ctrlD[5]),
        .i_BranchD     (ctrlD[4]),
        .i_JumpD       (ctrlD[3]),
        .i_ALUControlD (ctrlD[2:0]),
        .i_FlushE      (FlushE),
        .o_Rs1D        (Rs1D),
        .o_Rs2D        (Rs2D),
        .o_RD1E        (RD1E),
        .o_RD2E        (RD2E),
        .o_ImmExtE     (ImmExtE),
        .o_Rs1E        (Rs1E),
        .o_Rs2E        (Rs2E),
        .o_RdE         (RdE),
        .o_PCE         (PCE),
        .o_PCPlus4E    (PCPlus4E),
        .o_RegWriteE   (RegWriteE),
        .o_ResultSrcE  (ResultSrcE),
        .o_MemWriteE   (MemWriteE),
        .o_ALUSrcE     (ALUSrcE),
        .o_BranchE     (BranchE),
        .o_JumpE       (JumpE),
        .o_ALUControlE (ALUControlE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Immediate value as a signed offset: gather the format's bits into a
    // narrow field and let a signed cast stretch it to 32 bits.
    function automatic logic [31:0] immModel(input logic [31:0] ins, input logic [1:0] sel);
        logic [11:0] imm12;
        logic [12:0] immB;
        logic [20:0] immJ;
        case (sel)
            2'b00: begin
                imm12 = ins[31:20];
                return 32'($signed(imm12));
            end
            2'b01: begin
                imm12 = {ins[31:25], ins[11:7]};
                return 32'($signed(imm12));
            end
            2'b10: begin
                immB = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                return 32'($signed(immB));
            end
            default: begin
                immJ = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
                return 32'($signed(immJ));
            end
        endcase
    endfunction

    // Architectural view of a decode read: x0 is zero, a register being
    // written back right now reads as the value being written.
    function automatic logic [31:0] readReg(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (RegWriteW && RdW == idx) return ResultW;
        return modelRf[idx];
    endfunction

    function automatic eStage_t predict();
        eStage_t e;
        e.rs1  = InstrD[19:15];
        e.rs2  = InstrD[24:20];
        e.rd   = InstrD[11:7];
        e.rd1  = readReg(e.rs1);
        e.rd2  = readReg(e.rs2);
        e.imm  = immModel(InstrD, ImmSrcD);
        e.pc   = PCD;
        e.pcp4 = PCPlus4D;
        e.ctrl = ctrlD;
        return e;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) modelRf[i] <= 32'd0;
            expE <= '0;
        end else begin
            expE <= FlushE ? eStage_t'(0) : predict();
            if (RegWriteW && RdW != 5'd0) modelRf[RdW] <= ResultW;
        end
    end

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
        end
    endtask

    task automatic checkOutput();
        checkField("Rs1D", 32'(Rs1D), 32'(InstrD[19:15]));
        checkField("Rs2D", 32'(Rs2D), 32'(InstrD[24:20]));
        checkField("RD1E", RD1E, expE.rd1);
        checkField("RD2E", RD2E, expE.rd2);
        checkField("ImmExtE", ImmExtE, expE.imm);
        checkField("Rs1E", 32'(Rs1E), 32'(expE.rs1));
        checkField("Rs2E", 32'(Rs2E), 32'(expE.rs2));
        checkField("RdE", 32'(RdE), 32'(expE.rd));
        checkField("PCE", PCE, expE.pc);
        checkField("PCPlus4E", PCPlus4E, expE.pcp4);
        checkField("ctrlE", 32'({RegWriteE, ResultSrcE, MemWriteE, ALUSrcE, BranchE, JumpE, ALUControlE}),
                   32'(expE.ctrl));
    endtask

    always @(posedge clk) begin
        #1;
        if (checkEn) checkOutput();
    end

    function automatic logic [31:0] mkInstr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        logic [31:0] ins;
        ins        = $urandom;
        ins[19:15] = rs1;
        ins[24:20] = rs2;
        ins[11:7]  = rd;
        return ins;
    endfunction

    // Drives one decode cycle and returns just after the ID/EX load it causes.
    task automatic applyStimulus(input logic wbEn, input logic [4:0] wbRd, input logic [31:0] wbData,
                                 input logic [31:0] instr, input logic [1:0] immSrc, input logic flush,
                                 input logic [8:0] ctrl, input logic [31:0] pc);
        RegWriteW = wbEn;
        RdW       = wbRd;
        ResultW   = wbData;
        InstrD    = instr;
        ImmSrcD   = immSrc;
        FlushE    = flush;
        ctrlD     = ctrl;
        PCD       = pc;
        PCPlus4D  = pc + 32'd4;
        @(posedge clk);
        #2;
    endtask

    initial begin
        testsRun  = 0;
        failures  = 0;
        checkEn   = 1'b0;
        rst       = 1'b1;
        RegWriteW = 1'b0;
        RdW       = '0;
        ResultW   = '0;
        InstrD    = '0;
        PCD       = '0;
        PCPlus4D  = '0;
        ImmSrcD   = '0;
        ctrlD     = '0;
        FlushE    = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst     = 1'b0;
        checkEn = 1'b1;
        checkField("resetRD1E", RD1E, 32'd0);
        checkField("resetRegWriteE", 32'(RegWriteE), 32'd0);
        checkField("resetPCE", PCE, 32'd0);

        // Writeback to x5, then read it back through rs1.
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, mkInstr(5'd1, 5'd2, 5'd3), 2'b00, 1'b0, 9'h000, 32'h100);
        applyStimulus(1'b0, 5'd0, 32'd0, mkInstr(5'd5, 5'd0, 5'd4), 2'b00, 1'b0, 9'h1A5, 32'h104);
        checkField("wbThenReadX5", RD1E, 32'hDEADBEEF);

        // Same-cycle write of x7 and read of x7 on rs2, then read from the file.
        applyStimulus(1'b1, 5'd7, 32'h00001234, mkInstr(5'd0, 5'd7, 5'd8), 2'b01, 1'b0, 9'h0F0, 32'h108);
        checkField("bypassRD2E", RD2E, 32'h00001234);
        applyStimulus(1'b0, 5'd0, 32'd0, mkInstr(5'd7, 5'd0, 5'd8), 2'b01, 1'b0, 9'h0F0, 32'h10C);
        checkField("rfX7After", RD1E, 32'h00001234);

        // Writes to x0 are dropped, in the same cycle and afterwards.
        applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, mkInstr(5'd0, 5'd0, 5'd0), 2'b10, 1'b0, 9'h111, 32'h110);
        checkField("x0SameCycle", RD1E, 32'd0);
        applyStimulus(1'b0, 5'd0, 32'd0, mkInstr(5'd0, 5'd0, 5'd0), 2'b10, 1'b0, 9'h111, 32'h114);
        checkField("x0NextCycle", RD1E, 32'd0);

        // addi x1,x0,-1 and a B-type with all-ones upper bits (offset -4).
        applyStimulus(1'b0, 5'd0, 32'd0, 32'hFFF00093, 2'b00, 1'b0, 9'h120, 32'h118);
        checkField("immIType", ImmExtE, 32'hFFFFFFFF);
        checkField("rdIType", 32'(RdE), 32'd1);
        applyStimulus(1'b0, 5'd0, 32'd0, 32'hFE000EE3, 2'b10, 1'b0, 9'h010, 32'h11C);
        checkField("immBType", ImmExtE, 32'hFFFFFFFC);

        // A flush bubbles ID/EX while the writeback still reaches the file.
        applyStimulus(1'b1, 5'd9, 32'h0000ABCD, mkInstr(5'd1, 5'd2, 5'd3), 2'b11, 1'b1, 9'h108, 32'h40);
        checkField("flushRegWriteE", 32'(RegWriteE), 32'd0);
        checkField("flushJumpE", 32'(JumpE), 32'd0);
        checkField("flushPCE", PCE, 32'd0);
        checkField("flushRdE", 32'(RdE), 32'd0);
        applyStimulus(1'b0, 5'd0, 32'd0, mkInstr(5'd9, 5'd0, 5'd3), 2'b11, 1'b0, 9'h108, 32'h44);
        checkField("flushWbLanded", RD1E, 32'h0000ABCD);

        // Randomized traffic over a small register window to exercise bypass.
        for (int n = 0; n < 400; n++) begin
            applyStimulus(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                          mkInstr(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom)),
                          2'($urandom), ($urandom_range(0, 7) == 0), 9'($urandom), $urandom);
        end

        // Reset mid-run with a write pending: outputs clear at once, x5 reads 0.
        RegWriteW = 1'b1;
        RdW       = 5'd5;
        ResultW   = 32'h55555555;
        #1;
        rst = 1'b1;
        #1;
        checkField("asyncRstRD1E", RD1E, 32'd0);
        checkField("asyncRstRegWriteE", 32'(RegWriteE), 32'd0);
        checkField("asyncRstPCE", PCE, 32'd0);
        checkField("asyncRstImmExtE", ImmExtE, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'd0, mkInstr(5'd5, 5'd5, 5'd6), 2'b00, 1'b0, 9'h100, 32'h200);
        checkField("afterRstX5", RD1E, 32'd0);
        checkField("afterRstX5rs2", RD2E, 32'd0);

        repeat (2) @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule
